// File: rtl/main_decoder_if.sv
// Opcode/IRQ inputs and registered control outputs of the LEGv8 main decoder.
// The master drives Op/ExtIRQ; the slave (decoder) drives the control word.
interface main_decoder_if;
  logic [10:0] Op;
  logic        ExtIRQ;
  logic        Reg2Loc;
  logic [1:0]  ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [1:0]  ALUOp;
  logic [3:0]  EStatus;
  logic        ERet;
  logic        Exc;

  modport master (
    output Op, ExtIRQ,
    input  Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
    input  EStatus, ERet, Exc
  );

  modport slave (
    input  Op, ExtIRQ,
    output Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
    output EStatus, ERet, Exc
  );
endinterface

// File: rtl/main_decoder.sv
// LEGv8 main control decoder with exception support. Decodes Op/ExtIRQ into a
// control word that is registered, so control appears one cycle after sampling.
module main_decoder (
  input logic            clk,
  input logic            reset,
  main_decoder_if.slave  bus
);

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpCbz  = 11'b10110100???;
  localparam logic [10:0] OpEret = 11'b11010110100;
  localparam logic [10:0] OpMrs  = 11'b11010101001;

  localparam logic [1:0] SrcReg    = 2'b00;
  localparam logic [1:0] SrcImm    = 2'b01;
  localparam logic [1:0] SrcSysReg = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluPassB = 2'b01;
  localparam logic [1:0] AluRtype = 2'b10;

  localparam logic [3:0] EsNone    = 4'b0000;
  localparam logic [3:0] EsIrq     = 4'b0001;
  localparam logic [3:0] EsInvalid = 4'b0010;

  typedef struct packed {
    logic       reg2loc;
    logic [1:0] alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       eret;
    logic [3:0] estatus;
    logic       exc;
  } ctrl_t;

  ctrl_t ctrl_d, ctrl_q;

  // Starting from all-zero means every unused field is already driven low.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.estatus = EsNone;
    ctrl_d.alu_src = SrcReg;
    ctrl_d.alu_op  = AluAdd;
    if (bus.ExtIRQ) begin
      ctrl_d.estatus = EsIrq;
      ctrl_d.exc     = 1'b1;
    end else begin
      unique casez (bus.Op)
        OpAdd, OpSub, OpAnd, OpOrr: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = AluRtype;
        end
        OpLdur: begin
          ctrl_d.alu_src    = SrcImm;
          ctrl_d.mem_to_reg = 1'b1;
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.mem_read   = 1'b1;
          ctrl_d.alu_op     = AluAdd;
        end
        OpStur: begin
          ctrl_d.reg2loc   = 1'b1;
          ctrl_d.alu_src   = SrcImm;
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_op    = AluAdd;
        end
        OpCbz: begin
          ctrl_d.reg2loc = 1'b1;
          ctrl_d.branch  = 1'b1;
          ctrl_d.alu_op  = AluPassB;
        end
        OpEret: begin
          ctrl_d.alu_op = AluPassB;
          ctrl_d.eret   = 1'b1;
        end
        OpMrs: begin
          ctrl_d.reg2loc   = 1'b1;
          ctrl_d.alu_src   = SrcSysReg;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = AluPassB;
        end
        default: begin
          ctrl_d.estatus = EsInvalid;
          ctrl_d.exc     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.Reg2Loc  = ctrl_q.reg2loc;
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.MemtoReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.Branch   = ctrl_q.branch;
  assign bus.ALUOp    = ctrl_q.alu_op;
  assign bus.EStatus  = ctrl_q.estatus;
  assign bus.ERet     = ctrl_q.eret;
  assign bus.Exc      = ctrl_q.exc;

endmodule

// File: tb/tb_main_decoder.sv
// Directed bench for main_decoder: each task drives opcodes and compares the
// registered control word one cycle later against hand-written constants.
module tb_main_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  main_decoder_if bus ();

  main_decoder dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: Reg2Loc, ALUSrc[1:0], MemtoReg, RegWrite, MemRead, MemWrite, Branch,
  // ALUOp[1:0], ERet, EStatus[3:0], Exc
  localparam logic [15:0] W_ZERO = 16'h0000;
  localparam logic [15:0] W_R    = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0,
                                    4'b0000, 1'b0};
  localparam logic [15:0] W_LDUR = {1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0,
                                    4'b0000, 1'b0};
  localparam logic [15:0] W_STUR = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0,
                                    4'b0000, 1'b0};
  localparam logic [15:0] W_CBZ  = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0,
                                    4'b0000, 1'b0};
  localparam logic [15:0] W_ERET = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1,
                                    4'b0000, 1'b0};
  localparam logic [15:0] W_MRS  = {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0,
                                    4'b0000, 1'b0};
  localparam logic [15:0] W_INV  = {11'b0, 4'b0010, 1'b1};
  localparam logic [15:0] W_IRQ  = {11'b0, 4'b0001, 1'b1};

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ0 = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_ERET = 11'b11010110100;
  localparam logic [10:0] OP_MRS  = 11'b11010101001;
  localparam logic [10:0] OP_ONES = 11'b11111111111;

  function automatic logic [15:0] obs();
    return {bus.Reg2Loc, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
            bus.Branch, bus.ALUOp, bus.ERet, bus.EStatus, bus.Exc};
  endfunction

  task automatic step(input logic [10:0] op, input logic irq);
    bus.Op     = op;
    bus.ExtIRQ = irq;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(OP_ADD, 1'b1);
      got = obs();
      checks++;
      if (got !== W_ZERO) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, got, W_ZERO);
      end
    end
    rst_n = 1'b1;
    step(OP_ADD, 1'b0);
    got = obs();
    checks++;
    if (got !== W_R) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", got, W_R);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops [6];
    logic [15:0] exp [6];
    logic [15:0] got;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR};
    exp = '{W_R, W_R, W_R, W_R, W_LDUR, W_STUR};
    for (int i = 0; i < 6; i++) begin
      step(ops[i], 1'b0);
      got = obs();
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL b2b[%0d] op=%b: got %h expected %h", i, ops[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_cbz_sweep();
    logic [10:0] op;
    logic [15:0] got;
    for (int i = 0; i < 8; i++) begin
      op = OP_CBZ0 | 11'(i);
      step(op, 1'b0);
      got = obs();
      checks++;
      if (got !== W_CBZ) begin
        failures++;
        $display("FAIL cbz op=%b: got %h expected %h", op, got, W_CBZ);
      end
    end
    step(OP_CBNZ, 1'b0);
    got = obs();
    checks++;
    if (got !== W_INV) begin
      failures++;
      $display("FAIL cbnz_invalid: got %h expected %h", got, W_INV);
    end
  endtask

  task automatic test_invalid();
    logic [15:0] got;
    step(OP_ADD, 1'b0);
    step(OP_ONES, 1'b0);
    got = obs();
    checks++;
    if (got !== W_INV) begin
      failures++;
      $display("FAIL all_ones_invalid: got %h expected %h", got, W_INV);
    end
    step(11'b10001011001, 1'b0);
    got = obs();
    checks++;
    if (got !== W_INV) begin
      failures++;
      $display("FAIL add_nearmiss_invalid: got %h expected %h", got, W_INV);
    end
  endtask

  task automatic test_eret_mrs();
    logic [15:0] got;
    step(OP_ERET, 1'b0);
    got = obs();
    checks++;
    if (got !== W_ERET) begin
      failures++;
      $display("FAIL eret: got %h expected %h", got, W_ERET);
    end
    step(OP_MRS, 1'b0);
    got = obs();
    checks++;
    if (got !== W_MRS) begin
      failures++;
      $display("FAIL mrs: got %h expected %h", got, W_MRS);
    end
  endtask

  task automatic test_irq();
    logic [15:0] got;
    step(OP_LDUR, 1'b1);
    got = obs();
    checks++;
    if (got !== W_IRQ) begin
      failures++;
      $display("FAIL irq_ldur: got %h expected %h", got, W_IRQ);
    end
    step(OP_LDUR, 1'b0);
    got = obs();
    checks++;
    if (got !== W_LDUR) begin
      failures++;
      $display("FAIL irq_recover: got %h expected %h", got, W_LDUR);
    end
    step(OP_ERET, 1'b1);
    got = obs();
    checks++;
    if (got !== W_IRQ) begin
      failures++;
      $display("FAIL irq_over_eret: got %h expected %h", got, W_IRQ);
    end
    step(OP_ONES, 1'b1);
    got = obs();
    checks++;
    if (got !== W_IRQ) begin
      failures++;
      $display("FAIL irq_over_invalid: got %h expected %h", got, W_IRQ);
    end
  endtask

  task automatic test_reset_during_irq();
    logic [15:0] got;
    step(OP_LDUR, 1'b0);
    rst_n = 1'b0;
    step(OP_LDUR, 1'b1);
    got = obs();
    checks++;
    if (got !== W_ZERO) begin
      failures++;
      $display("FAIL reset_over_irq: got %h expected %h", got, W_ZERO);
    end
    rst_n = 1'b1;
    step(OP_STUR, 1'b0);
    got = obs();
    checks++;
    if (got !== W_STUR) begin
      failures++;
      $display("FAIL reset_resume: got %h expected %h", got, W_STUR);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.Op     = OP_ADD;
    bus.ExtIRQ = 1'b1;
    test_reset();
    test_back_to_back();
    test_cbz_sweep();
    test_invalid();
    test_eret_mrs();
    test_irq();
    test_reset_during_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
